// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared constants and types for the phase-3 control unit.
//   * 5-bit opcode map (ir[31:27])
//   * ALU operation codes driven onto the datapath opcode bus
//   * sequencer state enum and execute step numbers T3..T7
//   * instruction class enum produced by cu_instr_class
// Optional feature macro: CU_SINGLE_STEP_EN adds the S_WAIT state.
package cpu_pkg;

  // Opcode map
  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_MUL  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  // ALU operation codes (same encoding as the register-form opcodes)
  localparam logic [4:0] ADD_OP = 5'b00011;
  localparam logic [4:0] AND_OP = OP_AND;
  localparam logic [4:0] OR_OP  = OP_OR;

  // Register written directly by jal
  localparam int LINK_REG = 15;

  // Execute step numbers
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;
  localparam logic [2:0] T7 = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_EXEC,
    S_HALT
`ifdef CU_SINGLE_STEP_EN
    , S_WAIT
`endif
  } state_e;

  typedef enum logic [3:0] {
    CL_REG_ALU, CL_IMM_ALU, CL_LD, CL_LDI, CL_ST, CL_MULDIV, CL_UNARY, CL_BR,
    CL_JR, CL_JAL, CL_MFHI, CL_MFLO, CL_IN, CL_OUT, CL_NOP, CL_HALT
  } iclass_e;

  // Final execute step for each class; the sequencer leaves EXEC after it.
  function automatic logic [2:0] last_step(input iclass_e c);
    case (c)
      CL_REG_ALU, CL_IMM_ALU, CL_LDI: last_step = T5;
      CL_LD, CL_ST:                   last_step = T7;
      CL_MULDIV, CL_BR:               last_step = T6;
      CL_UNARY, CL_JAL:               last_step = T4;
      default:                        last_step = T3;
    endcase
  endfunction

endpackage

// File: rtl/cu_instr_class.sv
// cu_instr_class -- combinational decode of the opcode field into an
// instruction class that selects the execute microstep pattern.
// Ports:
//   opc_i    in  5  ir[31:27]
//   iclass_o out    instruction class (undefined opcodes map to CL_NOP)
module cu_instr_class
  import cpu_pkg::*;
(
  input  logic [4:0] opc_i,
  output iclass_e    iclass_o
);

  always_comb begin
    iclass_o = CL_NOP;
    case (opc_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: iclass_o = CL_REG_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:                iclass_o = CL_IMM_ALU;
      OP_LD:                                   iclass_o = CL_LD;
      OP_LDI:                                  iclass_o = CL_LDI;
      OP_ST:                                   iclass_o = CL_ST;
      OP_MUL, OP_DIV:                          iclass_o = CL_MULDIV;
      OP_NEG, OP_NOT:                          iclass_o = CL_UNARY;
      OP_BR:                                   iclass_o = CL_BR;
      OP_JR:                                   iclass_o = CL_JR;
      OP_JAL:                                  iclass_o = CL_JAL;
      OP_MFHI:                                 iclass_o = CL_MFHI;
      OP_MFLO:                                 iclass_o = CL_MFLO;
      OP_IN:                                   iclass_o = CL_IN;
      OP_OUT:                                  iclass_o = CL_OUT;
      OP_HALT:                                 iclass_o = CL_HALT;
      default:                                 iclass_o = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer -- hardwired control unit for the phase-3 CPU.
// Steps FETCH0..FETCH2 then execute steps T3..T7 per instruction class and
// drives every datapath strobe (Moore decode of state + ir).
// Ports:
//   clock, clear          clock; synchronous active-high reset
//   ir[31:0], con         IR contents and CON flag from the datapath
//   opcode[4:0]           ALU operation select
//   PCout..InPort_Out     bus drive selects (at most one high per cycle)
//   enableMAR..enableRAM  register / RAM write enables
//   IncPC..BAout          misc datapath controls
//   R_ins[15:0]           direct register write enables (jal link only)
//   run                   1 while executing, 0 once halted
//   step_req              (CU_SINGLE_STEP_EN only) release from S_WAIT
// Optional feature macro: CU_SINGLE_STEP_EN.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con,
`ifdef CU_SINGLE_STEP_EN
  input  logic        step_req,
`endif
  output logic [4:0]  opcode,
  output logic        PCout, Zhighout, Zlowout, HIout, LOout, Cout, MDRout, InPort_Out,
  output logic        enableMAR, enableMDR, enableIR, enableY, enableZ,
  output logic        enablePC, enableHI, enableLO, enableOutPort, enableRAM,
  output logic        IncPC, Read, conIn, Gra, Grb, Grc, Rin, Rout, BAout,
  output logic [15:0] R_ins,
  output logic        run
);

  state_e     state_q;
  logic [2:0] step_q;
  iclass_e    iclass;
  logic [4:0] alu_op;
  logic       unused_ir_bits;

  // Operand fields are consumed by the datapath select logic, not here.
  assign unused_ir_bits = ^ir[26:0];

  cu_instr_class u_class (
    .opc_i    (ir[31:27]),
    .iclass_o (iclass)
  );

  always_comb begin
    case (ir[31:27])
      OP_LD, OP_LDI, OP_ST, OP_BR, OP_ADDI: alu_op = ADD_OP;
      OP_ANDI:                              alu_op = AND_OP;
      OP_ORI:                               alu_op = OR_OP;
      default:                              alu_op = ir[31:27];
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_FETCH0;
      step_q  <= 3'd0;
    end else begin
      case (state_q)
        S_FETCH0: state_q <= S_FETCH1;
        S_FETCH1: state_q <= S_FETCH2;
        S_FETCH2: begin
          state_q <= S_EXEC;
          step_q  <= T3;
        end
        S_EXEC: begin
          if (step_q == last_step(iclass)) begin
            if (iclass == CL_HALT)
              state_q <= S_HALT;
            else
`ifdef CU_SINGLE_STEP_EN
              state_q <= S_WAIT;
`else
              state_q <= S_FETCH0;
`endif
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        S_HALT: state_q <= S_HALT;
`ifdef CU_SINGLE_STEP_EN
        S_WAIT: if (step_req) state_q <= S_FETCH0;
`endif
        default: state_q <= S_FETCH0;
      endcase
    end
  end

  always_comb begin
    opcode = 5'd0;
    {PCout, Zhighout, Zlowout, HIout, LOout, Cout, MDRout, InPort_Out} = 8'd0;
    {enableMAR, enableMDR, enableIR, enableY, enableZ} = 5'd0;
    {enablePC, enableHI, enableLO, enableOutPort, enableRAM} = 5'd0;
    {IncPC, Read, conIn, Gra, Grb, Grc, Rin, Rout, BAout} = 9'd0;
    R_ins = 16'd0;
    run   = 1'b1;
    // While clear is held nothing is strobed, so an interrupted
    // instruction cannot complete its current step.
    if (!clear) begin
      case (state_q)
        S_FETCH0: begin opcode = alu_op; PCout = 1'b1; enableMAR = 1'b1; IncPC = 1'b1; end
        S_FETCH1: begin opcode = alu_op; Read = 1'b1; enableMDR = 1'b1; end
        S_FETCH2: begin opcode = alu_op; MDRout = 1'b1; enableIR = 1'b1; end
        S_EXEC: begin
          opcode = alu_op;
          case (iclass)
            CL_REG_ALU, CL_IMM_ALU: case (step_q)
              T3: begin Grb = 1'b1; Rout = 1'b1; enableY = 1'b1; end
              T4: begin
                enableZ = 1'b1;
                if (iclass == CL_IMM_ALU) Cout = 1'b1;
                else begin Grc = 1'b1; Rout = 1'b1; end
              end
              T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
            CL_LD, CL_LDI, CL_ST: case (step_q)
              T3: begin Grb = 1'b1; BAout = 1'b1; enableY = 1'b1; end
              T4: begin Cout = 1'b1; enableZ = 1'b1; end
              T5: begin
                Zlowout = 1'b1;
                if (iclass == CL_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                else enableMAR = 1'b1;
              end
              T6: begin
                enableMDR = 1'b1;
                if (iclass == CL_ST) begin Gra = 1'b1; Rout = 1'b1; end
                else Read = 1'b1;
              end
              T7: begin
                if (iclass == CL_ST) enableRAM = 1'b1;
                else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              end
              default: ;
            endcase
            CL_MULDIV: case (step_q)
              T3: begin Gra = 1'b1; Rout = 1'b1; enableY = 1'b1; end
              T4: begin Grb = 1'b1; Rout = 1'b1; enableZ = 1'b1; end
              T5: begin Zlowout = 1'b1; enableLO = 1'b1; end
              T6: begin Zhighout = 1'b1; enableHI = 1'b1; end
              default: ;
            endcase
            CL_UNARY: case (step_q)
              T3: begin Grb = 1'b1; Rout = 1'b1; enableZ = 1'b1; end
              T4: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
            // T6 is an empty cycle when the branch is not taken so the
            // instruction length does not depend on con.
            CL_BR: case (step_q)
              T3: begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
              T4: begin PCout = 1'b1; enableY = 1'b1; end
              T5: begin Cout = 1'b1; enableZ = 1'b1; end
              T6: if (con) begin Zlowout = 1'b1; enablePC = 1'b1; end
              default: ;
            endcase
            CL_JR:   if (step_q == T3) begin Gra = 1'b1; Rout = 1'b1; enablePC = 1'b1; end
            CL_JAL: case (step_q)
              T3: begin PCout = 1'b1; R_ins[LINK_REG] = 1'b1; end
              T4: begin Gra = 1'b1; Rout = 1'b1; enablePC = 1'b1; end
              default: ;
            endcase
            CL_MFHI: if (step_q == T3) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            CL_MFLO: if (step_q == T3) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            CL_IN:   if (step_q == T3) begin InPort_Out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            CL_OUT:  if (step_q == T3) begin Gra = 1'b1; Rout = 1'b1; enableOutPort = 1'b1; end
            default: ;
          endcase
        end
        S_HALT: run = 1'b0;
`ifdef CU_SINGLE_STEP_EN
        S_WAIT: run = 1'b0;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        con;
  logic [4:0]  opcode;
  logic        PCout, Zhighout, Zlowout, HIout, LOout, Cout, MDRout, InPort_Out;
  logic        enableMAR, enableMDR, enableIR, enableY, enableZ;
  logic        enablePC, enableHI, enableLO, enableOutPort, enableRAM;
  logic        IncPC, Read, conIn, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [15:0] R_ins;
  logic        run;
`ifdef CU_SINGLE_STEP_EN
  logic        step_req = 1'b1;
`endif

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .con(con),
`ifdef CU_SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .opcode(opcode),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout),
    .LOout(LOout), .Cout(Cout), .MDRout(MDRout), .InPort_Out(InPort_Out),
    .enableMAR(enableMAR), .enableMDR(enableMDR), .enableIR(enableIR),
    .enableY(enableY), .enableZ(enableZ), .enablePC(enablePC),
    .enableHI(enableHI), .enableLO(enableLO), .enableOutPort(enableOutPort),
    .enableRAM(enableRAM), .IncPC(IncPC), .Read(Read), .conIn(conIn),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .R_ins(R_ins), .run(run)
  );

  // Strobe masks (bit position in the packed strobe word)
  localparam logic [26:0] PCO = 27'h1 << 26, ZHO = 27'h1 << 25, ZLO = 27'h1 << 24;
  localparam logic [26:0] HIO = 27'h1 << 23, LOO = 27'h1 << 22, CO  = 27'h1 << 21;
  localparam logic [26:0] MDO = 27'h1 << 20, INO = 27'h1 << 19, EMAR = 27'h1 << 18;
  localparam logic [26:0] EMDR = 27'h1 << 17, EIR = 27'h1 << 16, EY = 27'h1 << 15;
  localparam logic [26:0] EZ = 27'h1 << 14, EPC = 27'h1 << 13, EHI = 27'h1 << 12;
  localparam logic [26:0] ELO = 27'h1 << 11, EOUT = 27'h1 << 10, ERAM = 27'h1 << 9;
  localparam logic [26:0] INC = 27'h1 << 8, RD = 27'h1 << 7, CIN = 27'h1 << 6;
  localparam logic [26:0] GA = 27'h1 << 5, GB = 27'h1 << 4, GC = 27'h1 << 3;
  localparam logic [26:0] RIN = 27'h1 << 2, ROUT = 27'h1 << 1, BA = 27'h1;

  logic [26:0] strb_act;
  logic [9:0]  bus_act;
  assign strb_act = {PCout, Zhighout, Zlowout, HIout, LOout, Cout, MDRout, InPort_Out,
                     enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC,
                     enableHI, enableLO, enableOutPort, enableRAM,
                     IncPC, Read, conIn, Gra, Grb, Grc, Rin, Rout, BAout};
  assign bus_act = {PCout, Zhighout, Zlowout, HIout, LOout, Cout, MDRout, InPort_Out,
                    Rout, BAout};

  typedef struct {
    logic        clr;
    logic [31:0] ir;
    logic        con;
    logic [26:0] strb;
    logic [4:0]  opc;
    logic [15:0] rins;
    logic        run;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   ram_pulses = 0;
  bit   mon_on = 1'b0;

  task automatic row(input logic c, input logic [31:0] i, input logic cn,
                     input logic [26:0] s, input logic [4:0] op,
                     input logic [15:0] ri, input logic rn, input string nm);
    vec_t v;
    v.clr = c; v.ir = i; v.con = cn; v.strb = s; v.opc = op;
    v.rins = ri; v.run = rn; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic fetch(input logic [31:0] i, input logic [4:0] op, input string nm);
    row(0, i, 0, PCO | EMAR | INC, op, 16'h0, 1, {nm, "_F0"});
    row(0, i, 0, RD | EMDR,        op, 16'h0, 1, {nm, "_F1"});
    row(0, i, 0, MDO | EIR,        op, 16'h0, 1, {nm, "_F2"});
  endtask

  // Every cycle: bus drivers mutually exclusive; count enableRAM pulses.
  always @(negedge clock) begin
    #2;
    if (mon_on) begin
      checks++;
      if (!$onehot0(bus_act)) begin
        errors++;
        $display("FAIL bus_onehot t=%0t act=%b required at most one high", $time, bus_act);
      end
      if (enableRAM) ram_pulses++;
    end
  end

  initial begin
    logic [31:0] ld_i, add_i, br_i, jal_i, halt_i, st_i, nop_i, in_i, mul_i, andi_i;
    ld_i = 32'h01000095; add_i = 32'h19A28000; br_i = 32'h9A80000E;
    jal_i = 32'hAB000000; halt_i = 32'hD8000000; st_i = 32'h10800087;
    nop_i = 32'hD0000000; in_i = 32'hB0800000; mul_i = 32'h80000000;
    andi_i = 32'h68000000;

    row(1, ld_i, 0, 27'h0, 5'd0, 16'h0, 1, "reset");
    // ld R2,0x95: 8 cycles
    fetch(ld_i, 5'd3, "ld");
    row(0, ld_i, 0, GB | BA | EY,    5'd3, 16'h0, 1, "ld_T3");
    row(0, ld_i, 0, CO | EZ,         5'd3, 16'h0, 1, "ld_T4");
    row(0, ld_i, 0, ZLO | EMAR,      5'd3, 16'h0, 1, "ld_T5");
    row(0, ld_i, 0, RD | EMDR,       5'd3, 16'h0, 1, "ld_T6");
    row(0, ld_i, 0, MDO | GA | RIN,  5'd3, 16'h0, 1, "ld_T7");
    // add R3,R4,R5: 6 cycles
    fetch(add_i, 5'd3, "add");
    row(0, add_i, 0, GB | ROUT | EY, 5'd3, 16'h0, 1, "add_T3");
    row(0, add_i, 0, GC | ROUT | EZ, 5'd3, 16'h0, 1, "add_T4");
    row(0, add_i, 0, ZLO | GA | RIN, 5'd3, 16'h0, 1, "add_T5");
    // brzr taken then not taken: 7 cycles each
    for (int k = 0; k < 2; k++) begin
      logic cn;
      cn = (k == 0);
      fetch(br_i, 5'd3, "br");
      row(0, br_i, cn, GA | ROUT | CIN, 5'd3, 16'h0, 1, "br_T3");
      row(0, br_i, cn, PCO | EY,        5'd3, 16'h0, 1, "br_T4");
      row(0, br_i, cn, CO | EZ,         5'd3, 16'h0, 1, "br_T5");
      row(0, br_i, cn, cn ? (ZLO | EPC) : 27'h0, 5'd3, 16'h0, 1, cn ? "br_T6_taken" : "br_T6_not");
    end
    // jal R6
    fetch(jal_i, 5'd21, "jal");
    row(0, jal_i, 0, PCO,              5'd21, 16'h8000, 1, "jal_T3");
    row(0, jal_i, 0, GA | ROUT | EPC,  5'd21, 16'h0,    1, "jal_T4");
    // andi: Cout at T4, AND op
    fetch(andi_i, 5'd5, "andi");
    row(0, andi_i, 0, GB | ROUT | EY,  5'd5, 16'h0, 1, "andi_T3");
    row(0, andi_i, 0, CO | EZ,         5'd5, 16'h0, 1, "andi_T4");
    row(0, andi_i, 0, ZLO | GA | RIN,  5'd5, 16'h0, 1, "andi_T5");
    // mul
    fetch(mul_i, 5'd16, "mul");
    row(0, mul_i, 0, GA | ROUT | EY,   5'd16, 16'h0, 1, "mul_T3");
    row(0, mul_i, 0, GB | ROUT | EZ,   5'd16, 16'h0, 1, "mul_T4");
    row(0, mul_i, 0, ZLO | ELO,        5'd16, 16'h0, 1, "mul_T5");
    row(0, mul_i, 0, ZHO | EHI,        5'd16, 16'h0, 1, "mul_T6");
    // nop then in
    fetch(nop_i, 5'd26, "nop");
    row(0, nop_i, 0, 27'h0,            5'd26, 16'h0, 1, "nop_T3");
    fetch(in_i, 5'd22, "in");
    row(0, in_i, 0, INO | GA | RIN,    5'd22, 16'h0, 1, "in_T3");
    // halt: T3 empty, then idle 20 cycles with run low
    fetch(halt_i, 5'd27, "halt");
    row(0, halt_i, 0, 27'h0,           5'd27, 16'h0, 1, "halt_T3");
    for (int k = 0; k < 20; k++)
      row(0, halt_i, 0, 27'h0,         5'd0,  16'h0, 0, "halt_idle");
    row(1, st_i, 0, 27'h0,             5'd0,  16'h0, 1, "halt_clear");
    // st interrupted by clear at T6
    fetch(st_i, 5'd3, "st_a");
    row(0, st_i, 0, GB | BA | EY,      5'd3, 16'h0, 1, "st_a_T3");
    row(0, st_i, 0, CO | EZ,           5'd3, 16'h0, 1, "st_a_T4");
    row(0, st_i, 0, ZLO | EMAR,        5'd3, 16'h0, 1, "st_a_T5");
    row(1, st_i, 0, 27'h0,             5'd0, 16'h0, 1, "st_a_clear_T6");
    // restarts at FETCH0; run the full st
    fetch(st_i, 5'd3, "st_b");
    row(0, st_i, 0, GB | BA | EY,      5'd3, 16'h0, 1, "st_b_T3");
    row(0, st_i, 0, CO | EZ,           5'd3, 16'h0, 1, "st_b_T4");
    row(0, st_i, 0, ZLO | EMAR,        5'd3, 16'h0, 1, "st_b_T5");
    row(0, st_i, 0, GA | ROUT | EMDR,  5'd3, 16'h0, 1, "st_b_T6");
    row(0, st_i, 0, ERAM,              5'd3, 16'h0, 1, "st_b_T7");
    fetch(ld_i, 5'd3, "next");

    clear = 1'b1; ir = ld_i; con = 1'b0;
    repeat (2) @(posedge clock);
    mon_on = 1'b1;

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clock);
      clear = vecs[n].clr; ir = vecs[n].ir; con = vecs[n].con;
      #1;
      checks++;
      if (strb_act !== vecs[n].strb) begin
        errors++;
        $display("FAIL %s[%0d] strobes got %b want %b", vecs[n].name, n, strb_act, vecs[n].strb);
      end
      checks++;
      if (opcode !== vecs[n].opc) begin
        errors++;
        $display("FAIL %s[%0d] opcode got %0d want %0d", vecs[n].name, n, opcode, vecs[n].opc);
      end
      checks++;
      if (R_ins !== vecs[n].rins) begin
        errors++;
        $display("FAIL %s[%0d] R_ins got %h want %h", vecs[n].name, n, R_ins, vecs[n].rins);
      end
      checks++;
      if (run !== vecs[n].run) begin
        errors++;
        $display("FAIL %s[%0d] run got %b want %b", vecs[n].name, n, run, vecs[n].run);
      end
      $display("row %0d %s clr=%b ir=%h con=%b strb=%h opc=%0d rins=%h run=%b",
               n, vecs[n].name, clear, ir, con, strb_act, opcode, R_ins, run);
    end

    @(negedge clock);
    #3;
    mon_on = 1'b0;
    // Only the completed st may have written RAM; the aborted one must not.
    checks++;
    if (ram_pulses != 1) begin
      errors++;
      $display("FAIL ram_pulse_count got %0d want 1", ram_pulses);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that directly feeds the phase-2 datapath.
- Reads the IR contents and the CON flag back from the datapath.
- Steps through fetch and per-opcode execute microsteps, driving every datapath control strobe for the current step.
- Replaces the bench-driven control of phase 2; the datapath plus this block forms the phase-3 CPU.

Parameters:
- ADD_OP, 5'b00011, ALU opcode used for address, branch and addi arithmetic.
- LINK_REG, 15, register written by jal.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- clear  input  1  synchronous active-high reset.
- ir  input  32  IR contents; [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc.
- con  input  1  CON flip-flop output.
- opcode  output  5  ALU operation select.
- PCout, Zhighout, Zlowout, HIout, LOout, Cout, MDRout, InPort_Out  output  1 each  bus drive selects.
- enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC, enableHI, enableLO, enableOutPort, enableRAM  output  1 each  register/RAM write enables.
- IncPC, Read, conIn, Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  datapath controls.
- R_ins  output  16  direct register write enables; used only for the jal link.
- run  output  1  1 while executing; 0 after halt.

Behaviour:
- Clear:
  - Synchronous; the next state is FETCH0 with step = 0.
  - All outputs are 0 except run = 1.
  - Clear asserted mid-instruction abandons that instruction; no further strobes are issued.
- Outputs are Moore, decoded from the current state and ir, so every strobe is valid for exactly one cycle.
- States: FETCH0, FETCH1, FETCH2, EXEC (3-bit step counter T3..T7), HALT.
- Fetch sequence:
  - FETCH0: PCout, enableMAR, IncPC.
  - FETCH1: Read, enableMDR.
  - FETCH2: MDRout, enableIR.
  - FETCH2 -> EXEC at T3.
- The last step of every instruction returns to FETCH0.
- Default opcode output = ir[31:27]; ADD_OP for ld/ldi/st/br/addi; AND for andi; OR for ori.
- Execute steps by instruction:
  - Reg ALU ops (add, sub, and, or, shifts, rotates): T3 Grb Rout enableY; T4 Grc Rout enableZ; T5 Zlowout Gra Rin.
  - addi/andi/ori: same as reg ALU ops, but T4 drives Cout instead of Grc Rout.
  - ld: T3 Grb BAout enableY; T4 Cout enableZ; T5 Zlowout enableMAR; T6 Read enableMDR; T7 MDRout Gra Rin.
  - ldi: T3-T4 as ld; T5 Zlowout Gra Rin.
  - st: T3-T5 as ld; T6 Gra Rout enableMDR (Read = 0); T7 enableRAM.
  - mul/div: T3 Gra Rout enableY; T4 Grb Rout enableZ; T5 Zlowout enableLO; T6 Zhighout enableHI.
  - neg/not: T3 Grb Rout enableZ; T4 Zlowout Gra Rin.
  - br: T3 Gra Rout conIn; T4 PCout enableY; T5 Cout enableZ; T6 Zlowout enablePC only if con = 1, else an empty cycle (fixed 7-cycle length either way).
  - jr: T3 Gra Rout enablePC.
  - jal: T3 PCout R_ins[LINK_REG]; T4 Gra Rout enablePC.
  - mfhi/mflo: T3 HIout/LOout Gra Rin.
  - in: T3 InPort_Out Gra Rin.
  - out: T3 Gra Rout enableOutPort.
  - nop and undefined opcodes: no T3 strobes; T3 returns to FETCH0.
  - halt (11011): EXEC T3 -> HALT; run = 0; all strobes 0; HALT exits only on clear.
- Opcode map (team decision): ld 0, ldi 1, st 2, add 3, sub 4, and 5, or 6, ror 7, rol 8, shr 9, shra 10, shl 11, addi 12, andi 13, ori 14, div 15, mul 16, neg 17, not 18, br 19, jr 20, jal 21, in 22, out 23, mfhi 24, mflo 25, nop 26, halt 27.
- No two bus-drive selects are ever high in the same cycle; the verifier asserts this every cycle.

Optional Feature:
- Macro: CU_SINGLE_STEP_EN.
- With the macro defined:
  - Adds input step_req (1 bit) and state WAIT.
  - The last execute step goes to WAIT instead of FETCH0.
  - WAIT moves to FETCH0 on the cycle after step_req = 1.
  - run = 0 in WAIT.
  - Clear still goes to FETCH0.
- Without the macro: no port, no WAIT state, free-running.

Decomposition:
- cpu_pkg holds:
  - 5-bit opcode constants (the map above);
  - ALU op constants;
  - the state enum;
  - the step-count constants T3..T7.
- One natural sub-module: cu_instr_class, a combinational decode of ir[31:27] into an instruction class (REG_ALU, IMM_ALU, LD, LDI, ST, MULDIV, UNARY, BR, JR, JAL, MFHI, MFLO, IN, OUT, NOP, HALT).
- The sequencer FSM stays in control_sequencer.

Test Plan:
- Release clear, ir = 0x01000095 (ld R2,0x95):
  - FETCH0/1/2 strobes in cycles 1-3.
  - T5 Zlowout+enableMAR; T7 MDRout+Gra+Rin.
  - FETCH0 in cycle 9 (8 cycles total).
- ir = 0x19A28000 (add R3,R4,R5):
  - T3 Grb Rout enableY; T4 Grc Rout enableZ with opcode = 3; T5 Zlowout Gra Rin.
  - 6-cycle instruction.
- ir = 0x9A80000E (brzr R5,14), con = 1 at T6:
  - T6 Zlowout enablePC.
  - Repeat with con = 0: T6 shows no strobes.
- ir = 0xAB000000 (jal R6):
  - T3 PCout with R_ins = 0x8000; T4 Gra Rout enablePC.
- ir = 0xD8000000 (halt):
  - run falls after T3 and outputs stay 0 for 20 cycles.
  - Assert clear for 1 cycle: FETCH0 strobes follow and run = 1.
- Clear asserted at st T6 (ir = 0x10800087):
  - No enableRAM pulse.
  - Next cycle is FETCH0.
  - Every cycle of the run has at most one bus-drive select high.
